// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage word load/store responder with wait-state latency
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mre_i,
  input  logic        mwe_i,
  input  logic [31:0] maddr_i,
  input  logic [31:0] mwdata_i,
  input  logic [4:0]  waddr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [4:0]  waddr_o,
  output logic        we_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        maddr_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, next_state;
  logic [3:0]      cnt;
  logic [31:0]     rdata_q;
  logic [31:0]     mem [DEPTH_WORDS];
  logic [31:0]     ram_rdata;
  logic [AW-1:0]   idx;
  logic            is_load, is_store, aligned;
  logic            ram_we, rd_load;
  logic            unused_addr;

  assign is_load   = mre_i & ~mwe_i;
  assign is_store  = mwe_i & ~mre_i;
  assign aligned   = (maddr_i[1:0] == 2'b00);
  // upper address bits are dropped so accesses wrap around the RAM
  assign idx       = maddr_i[AW+1:2];
  assign ram_rdata = mem[idx];
  assign unused_addr = ^maddr_i[31:AW+2];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[idx] <= mwdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == BUSY) begin
        cnt <= LAT_M1;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (rd_load) begin
        rdata_q <= ram_rdata;
      end
    end
  end

  always_comb begin
    next_state  = state;
    waddr_o     = waddr_i;
    we_o        = we_i;
    wdata_o     = wdata_i;
    stallreq_o  = 1'b0;
    maddr_err_o = 1'b0;
    ram_we      = 1'b0;
    rd_load     = 1'b0;
    case (state)
      IDLE: begin
        if (is_load || is_store) begin
          if (!aligned) begin
            maddr_err_o = 1'b1;
            we_o        = 1'b0;
          end else if (LATENCY == 0) begin
            if (is_load) begin
              wdata_o = ram_rdata;
            end else begin
              ram_we = 1'b1;
            end
          end else begin
            next_state = BUSY;
            stallreq_o = 1'b1;
            we_o       = 1'b0;
          end
        end
      end
      BUSY: begin
        stallreq_o = 1'b1;
        we_o       = 1'b0;
        if (cnt == 4'd0) begin
          next_state = DONE;
          rd_load    = is_load;
        end
      end
      DONE: begin
        next_state = IDLE;
        if (is_load) begin
          wdata_o = rdata_q;
        end else if (is_store) begin
          ram_we = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    // reset forces quiet outputs and abandons any pending store
    if (rst) begin
      next_state  = IDLE;
      waddr_o     = 5'd0;
      we_o        = 1'b0;
      wdata_o     = 32'd0;
      stallreq_o  = 1'b0;
      maddr_err_o = 1'b0;
      ram_we      = 1'b0;
      rd_load     = 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mre, mwe, we;
  logic [31:0] maddr, mwdata, wdata;
  logic [4:0]  waddr;
  logic [4:0]  waddr_o;
  logic        we_o, stall_o, err_o;
  logic [31:0] wdata_o;

  logic        mre0, mwe0, we0;
  logic [31:0] maddr0, mwdata0, wdata0;
  logic [4:0]  waddr0;
  logic [4:0]  waddr_o0;
  logic        we_o0, stall_o0, err_o0;
  logic [31:0] wdata_o0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .mre_i(mre), .mwe_i(mwe), .maddr_i(maddr),
    .mwdata_i(mwdata), .waddr_i(waddr), .we_i(we), .wdata_i(wdata),
    .waddr_o(waddr_o), .we_o(we_o), .wdata_o(wdata_o),
    .stallreq_o(stall_o), .maddr_err_o(err_o)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .mre_i(mre0), .mwe_i(mwe0), .maddr_i(maddr0),
    .mwdata_i(mwdata0), .waddr_i(waddr0), .we_i(we0), .wdata_i(wdata0),
    .waddr_o(waddr_o0), .we_o(we_o0), .wdata_o(wdata_o0),
    .stallreq_o(stall_o0), .maddr_err_o(err_o0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    mre = 0; mwe = 0; maddr = 0; mwdata = 0; waddr = 0; we = 0; wdata = 0;
  endtask

  // Runs one access on the L=2 instance; returns stall count and DONE-cycle outputs.
  task automatic access(input logic ld, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] wa, input logic wen, output int stalls,
                        output logic [31:0] d_done, output logic we_done,
                        output logic [4:0] wa_done, output logic err_done);
    mre = ld; mwe = !ld; maddr = addr; mwdata = data; waddr = wa; we = wen;
    wdata = 32'hA5A5_0000;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!stall_o) break;
      stalls++;
      @(posedge clk);
    end
    d_done = wdata_o; we_done = we_o; wa_done = waddr_o; err_done = err_o;
    @(posedge clk); #1;
    clear_inputs();
  endtask

  int          st;
  logic [31:0] d;
  logic        w, e;
  logic [4:0]  a;

  initial begin
    clear_inputs();
    mre0 = 0; mwe0 = 0; maddr0 = 0; mwdata0 = 0; waddr0 = 0; we0 = 0; wdata0 = 0;
    rst = 1;
    mre = 1; waddr = 5'd7; we = 1; wdata = 32'hFFFF_FFFF; maddr = 32'h10;
    @(posedge clk); #1;
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_we", {31'd0, we_o}, 32'd0);
    check("rst_waddr", {27'd0, waddr_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    clear_inputs();

    // passthrough
    waddr = 5'd3; we = 1; wdata = 32'h0000_1234; #1;
    check("pt_wdata", wdata_o, 32'h0000_1234);
    check("pt_waddr", {27'd0, waddr_o}, 32'd3);
    check("pt_we", {31'd0, we_o}, 32'd1);
    check("pt_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    check("pt_stall2", {31'd0, stall_o}, 32'd0);
    clear_inputs();

    // store then load, same word
    access(0, 32'h10, 32'hDEADBEEF, 5'd0, 0, st, d, w, a, e);
    check("st_stalls", st, 32'd3);
    check("st_done_wdata", d, 32'hA5A5_0000);
    access(1, 32'h10, 32'd0, 5'd8, 1, st, d, w, a, e);
    check("ld_stalls", st, 32'd3);
    check("ld_wdata", d, 32'hDEADBEEF);
    check("ld_we", {31'd0, w}, 32'd1);
    check("ld_waddr", {27'd0, a}, 32'd8);
    check("ld_err_done", {31'd0, e}, 32'd0);

    // misaligned load
    mre = 1; maddr = 32'h13; waddr = 5'd4; we = 1; #1;
    check("mis_err", {31'd0, err_o}, 32'd1);
    check("mis_we", {31'd0, we_o}, 32'd0);
    check("mis_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    clear_inputs(); #1;
    check("mis_err_after", {31'd0, err_o}, 32'd0);
    check("mis_idle", {31'd0, stall_o}, 32'd0);

    // reset mid-store abandons the write
    access(0, 32'h20, 32'h1111_1111, 5'd0, 0, st, d, w, a, e);
    mwe = 1; maddr = 32'h20; mwdata = 32'h5555_5555; #1;
    check("rs_stall_T", {31'd0, stall_o}, 32'd1);
    @(posedge clk); #1;
    rst = 1; #1;
    check("rs_wdata", wdata_o, 32'd0);
    check("rs_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    clear_inputs(); #1;
    check("rs_idle_stall", {31'd0, stall_o}, 32'd0);
    check("rs_idle_we", {31'd0, we_o}, 32'd0);
    @(posedge clk); #1;
    access(1, 32'h20, 32'd0, 5'd9, 1, st, d, w, a, e);
    check("rs_load", d, 32'h1111_1111);

    // address wrap
    access(0, 32'h1000, 32'hCAFE0001, 5'd0, 0, st, d, w, a, e);
    access(1, 32'h0, 32'd0, 5'd2, 1, st, d, w, a, e);
    check("wrap_load", d, 32'hCAFE0001);

    // zero-latency instance: store then load on consecutive cycles
    mwe0 = 1; maddr0 = 32'h40; mwdata0 = 32'h1234_5678; #1;
    check("l0_st_stall", {31'd0, stall_o0}, 32'd0);
    @(posedge clk); #1;
    mwe0 = 0; mre0 = 1; waddr0 = 5'd5; we0 = 1; #1;
    check("l0_ld_stall", {31'd0, stall_o0}, 32'd0);
    check("l0_ld_wdata", wdata_o0, 32'h1234_5678);
    check("l0_ld_we", {31'd0, we_o0}, 32'd1);
    @(posedge clk); #1;
    mre0 = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the data-access requests the execute stage issues through ex_mem. Sits in the MEM stage between ex_mem and mem_wb. Services word loads and stores against an internal synchronous data RAM with a configurable wait-state latency, stalling the pipeline through ctrl while an access is in flight. Passes non-memory results straight through to write-back.

## Interface
- DEPTH_WORDS, 1024: data RAM depth in 32-bit words; power of two.
- LATENCY, 2: wait cycles per memory access; range 0..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- mre_i  in  1  load request, from ex_mem.
- mwe_i  in  1  store request, from ex_mem.
- maddr_i  in  32  byte address of the access.
- mwdata_i  in  32  store data.
- waddr_i  in  5  destination register.
- we_i  in  1  register write enable.
- wdata_i  in  32  ALU or link result.
- waddr_o  out  5  destination register, to mem_wb.
- we_o  out  1  register write enable, to mem_wb.
- wdata_o  out  32  write-back data, to mem_wb.
- stallreq_o  out  1  stall request, to ctrl.
- maddr_err_o  out  1  misaligned-access flag, one cycle.

## Operation
- Access classification:
  - Load: mre_i=1, mwe_i=0.
  - Store: mwe_i=1, mre_i=0.
  - No access: both 0 or both 1.
- Access is word only. maddr_i[1:0]!=0 makes the access misaligned:
  - no RAM access, no stall;
  - maddr_err_o=1 in that cycle;
  - we_o=0.
- RAM word index is maddr_i[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses alias (wrap).
- No access: waddr_o, we_o and wdata_o equal the inputs combinationally; stallreq_o=0.
- FSM states and transitions:
  - IDLE → BUSY on an aligned access when LATENCY>0. The cycle count is loaded with LATENCY-1.
  - BUSY counts down. BUSY → DONE when the count is 0.
  - DONE → IDLE unconditionally.
- stallreq_o=1 in two cases: IDLE with an aligned access and LATENCY>0, and BUSY. ctrl holds ex_mem stable while stalled, so the request inputs are constant until DONE.
- Load:
  - RAM read data is registered into an internal read register during the last stalled cycle.
  - In DONE: wdata_o = read register, we_o = we_i, waddr_o = waddr_i.
- Store:
  - RAM written exactly once, at the clock edge ending DONE.
  - wdata_o = wdata_i, we_o = we_i.
- LATENCY=0:
  - The FSM stays in IDLE and there is no stall.
  - Load data comes from a combinational/async read path in the same cycle.
  - A store commits at the end of that cycle.
- Reset (rst=1):
  - Next state is IDLE and the counter and read register are cleared.
  - All outputs are 0 while rst=1: waddr_o, we_o, wdata_o, stallreq_o, maddr_err_o.
  - RAM contents are not cleared.
  - Reset mid-access abandons the access. A pending store is never written.

## Timing
- Request presented in cycle T, LATENCY=L>0:
  - stallreq_o high in cycles T..T+L.
  - Cycle T+L+1 is DONE with stallreq_o low; results are valid and mem_wb captures them at the end of that cycle.
  - Total occupancy is L+2 cycles.
- The cycle after DONE is IDLE and evaluates the next instruction immediately; a following access stalls that same cycle with no bubble.
- A load after a store to the same word sees the stored data, because the store committed at the end of the store's DONE.
- maddr_err_o is combinational from IDLE-state inputs. It is never asserted in BUSY or DONE.

## Test plan
- Store then load, L=2:
  - Store 0xDEADBEEF to 0x0000_0010. Then load 0x10 with waddr_i=8, we_i=1.
  - Each access holds stallreq_o=1 for exactly 3 cycles.
  - In the load's DONE cycle: wdata_o=0xDEADBEEF, we_o=1, waddr_o=8.
- Passthrough: mre_i=mwe_i=0, wdata_i=0x0000_1234, waddr_i=3, we_i=1 → the same values appear on the outputs in the same cycle; stallreq_o=0 throughout.
- Misaligned: load at 0x0000_0013 → maddr_err_o=1 for one cycle, we_o=0, stallreq_o=0, FSM stays IDLE.
- Reset mid-access:
  - Store 0x5555_5555 to 0x20 (RAM previously holds 0x1111_1111 there). Assert rst in the first BUSY cycle.
  - Next cycle: all outputs 0, FSM in IDLE.
  - A later load of 0x20 returns 0x1111_1111.
- Wrap, DEPTH_WORDS=1024: store 0xCAFE0001 to 0x0000_1000, then load 0x0000_0000 → 0xCAFE0001.
- L=0: a store followed by a load on consecutive cycles → never stalls; the load returns the stored value in its own cycle.
